// File: rtl/apu_event_trigger.sv
// Sound-event trigger: edge-detects game events and stretches them into per-channel
// sound enables for HOLD_FRAMES frames. Latency 1 cycle, all outputs registered. No backpressure.
// Optional build macro APU_TRIG_EXCLUSIVE_EN: single active channel with priority preemption.
module apu_event_trigger #(
    parameter int                NUM_CH       = 4,
    parameter int                HOLD_FRAMES  = 2,
    parameter logic [NUM_CH-1:0] SUSTAIN_MASK = {NUM_CH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_end,
    input  logic                      test_mode,
    input  logic [NUM_CH-1:0]         event_in,
    output logic [NUM_CH-1:0]         sound_out,
    output logic                      sound_any,
    output logic [$clog2(NUM_CH)-1:0] sound_id,
    output logic [NUM_CH-1:0]         sound_start
);

    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam int ID_W  = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] sout_nxt;
    logic [NUM_CH-1:0] start_nxt;
    logic              any_nxt;
    logic [ID_W-1:0]   id_nxt;
    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];

    assign rise = event_in & ~prev;

`ifdef APU_TRIG_EXCLUSIVE_EN
    // A rise is blocked by any lower channel that is active or rising this cycle.
    always_comb begin
        logic blk;
        blk = 1'b0;
        acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc[i] = rise[i] & ~blk;
            blk    = blk | rise[i] | (cnt[i] != '0);
        end
    end
`else
    assign acc = rise;
`endif

    always_comb begin
`ifdef APU_TRIG_EXCLUSIVE_EN
        logic kill;
        kill = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (test_mode) begin
                cnt_nxt[i] = '0;
            end else if (acc[i]) begin
                cnt_nxt[i] = HOLD_LD;
            end else if (frame_end && (cnt[i] != '0)) begin
                // Sustained channels park at 1 while their event is still high.
                if (!(SUSTAIN_MASK[i] && event_in[i] && (cnt[i] == CNT_ONE))) begin
                    cnt_nxt[i] = cnt[i] - CNT_ONE;
                end
            end
`ifdef APU_TRIG_EXCLUSIVE_EN
            if (kill) begin
                cnt_nxt[i] = '0;
            end
            kill = kill | acc[i];
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sout_nxt[i] = test_mode ? event_in[i] : (cnt_nxt[i] != '0);
        end
        start_nxt = sout_nxt & ~sound_out;
        any_nxt   = |sout_nxt;
        id_nxt    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (sout_nxt[i]) begin
                id_nxt = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= '0;
            sound_out   <= '0;
            sound_any   <= 1'b0;
            sound_id    <= '0;
            sound_start <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            prev        <= event_in;
            sound_out   <= sout_nxt;
            sound_any   <= any_nxt;
            sound_id    <= id_nxt;
            sound_start <= start_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_apu_event_trigger.sv
// Bench for apu_event_trigger: directed scenarios then random traffic, checked by a
// queue-based scoreboard fed from a frame-count reference model.
module tb_apu_event_trigger;

    localparam int NUM_CH = 4;
    localparam int HOLD   = 2;
    localparam logic [3:0] SMASK = 4'b0100;

    logic       clk = 1'b0;
    logic       reset, frame_end, test_mode;
    logic [3:0] event_in;
    logic [3:0] sound_out, sound_start;
    logic       sound_any;
    logic [1:0] sound_id;

    apu_event_trigger #(
        .NUM_CH(NUM_CH), .HOLD_FRAMES(HOLD), .SUSTAIN_MASK(SMASK)
    ) dut (
        .clk(clk), .reset(reset), .frame_end(frame_end), .test_mode(test_mode),
        .event_in(event_in), .sound_out(sound_out), .sound_any(sound_any),
        .sound_id(sound_id), .sound_start(sound_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] so;
        logic       any;
        logic [1:0] id;
        logic [3:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference state: frames left per channel, last seen event levels, last enables.
    int         m_left[4];
    logic [3:0] m_prev = '0;
    logic [3:0] m_so   = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic fe, input logic tm, input logic [3:0] ev);
        exp_t       e;
        logic [3:0] rs, acc, nso;
        int         win;
        if (r) begin
            for (int i = 0; i < 4; i++) m_left[i] = 0;
            m_prev = '0;
            m_so   = '0;
            e      = '0;
        end else begin
            rs  = ev & ~m_prev;
            nso = '0;
            win = -1;
            if (tm) begin
                for (int i = 0; i < 4; i++) m_left[i] = 0;
                nso = ev;
            end else begin
`ifdef APU_TRIG_EXCLUSIVE_EN
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    if (rs[j]) begin win = j; break; end
                    if (m_left[j] > 0) break;
                end
                if (win >= 0) acc[win] = 1'b1;
`else
                acc = rs;
`endif
                for (int i = 0; i < 4; i++) begin
                    if (acc[i]) m_left[i] = HOLD;
                    else if (win >= 0 && i > win) m_left[i] = 0;
                    else if (fe && m_left[i] > 0) begin
                        if (!(SMASK[i] && ev[i] && m_left[i] == 1)) m_left[i] = m_left[i] - 1;
                    end
                    nso[i] = (m_left[i] > 0);
                end
            end
            e.so  = nso;
            e.st  = nso & ~m_so;
            e.any = |nso;
            e.id  = 2'd0;
            for (int i = 3; i >= 0; i--) if (nso[i]) e.id = 2'(i);
            m_so   = nso;
            m_prev = ev;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic fe, input logic tm, input logic [3:0] ev);
        @(negedge clk);
        reset     = r;
        frame_end = fe;
        test_mode = tm;
        event_in  = ev;
        model(r, fe, tm, ev);
    endtask

    task automatic run(input int n, input logic [3:0] ev);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, ev);
    endtask

    task automatic fe_pulse(input logic [3:0] ev);
        step(1'b0, 1'b1, 1'b0, ev);
    endtask

    // Monitor: outputs are presented every cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sound_out",   int'(sound_out),   int'(e.so));
                chk("sound_start", int'(sound_start), int'(e.st));
                chk("sound_any",   int'(sound_any),   int'(e.any));
                chk("sound_id",    int'(sound_id),    int'(e.id));
            end
        end
    end

    initial begin
        logic [3:0] ev;
        logic       tm;
        reset = 1'b1; frame_end = 1'b0; test_mode = 1'b0; event_in = '0;
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 1'b0, 4'b0000);

        // Single trigger, two-frame hold
        run(8, 4'b0000);
        run(10, 4'b0001);
        fe_pulse(4'b0001);
        run(19, 4'b0001);
        fe_pulse(4'b0001);
        run(4, 4'b0000);

        // Rise coincident with frame_end
        fe_pulse(4'b0010);
        run(9, 4'b0010);
        fe_pulse(4'b0010);
        run(5, 4'b0000);
        fe_pulse(4'b0000);
        run(3, 4'b0000);

        // Sustained ch2 versus plain ch3 under identical stimulus
        step(1'b0, 1'b0, 1'b0, 4'b1100);
        for (int f = 0; f < 5; f++) begin
            run(4, 4'b1100);
            fe_pulse(4'b1100);
        end
        run(3, 4'b0000);
        fe_pulse(4'b0000);
        run(3, 4'b0000);

        // Staggered rises, retrigger mid-hold
        step(1'b0, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 1'b0, 1'b0, 4'b1010);
        run(3, 4'b1010);
        fe_pulse(4'b1010);
        step(1'b0, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 1'b0, 1'b0, 4'b1010);
        run(3, 4'b1010);
        fe_pulse(4'b0000);
        fe_pulse(4'b0000);
        fe_pulse(4'b0000);
        run(2, 4'b0000);

        // Events held through reset, then reset mid-hold
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 4'b1111);
        run(3, 4'b1111);
        step(1'b1, 1'b0, 1'b0, 4'b1111);
        run(3, 4'b1111);
        run(2, 4'b0000);

        // Test-mode bypass and clean exit
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, (k % 2 == 0) ? 4'b0101 : 4'b0000);
        step(1'b0, 1'b0, 1'b1, 4'b0101);
        step(1'b0, 1'b1, 1'b1, 4'b0101);
        run(4, 4'b0101);
        fe_pulse(4'b0101);
        run(2, 4'b0000);

        // Random traffic
        ev = '0;
        tm = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) ev = ev ^ 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) tm = ~tm;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), tm, ev);
        end
        run(2, 4'b0000);

        // Drain: bounded wait for the monitor to consume everything
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
